// File: rtl/sram_burst_ctrl_if.sv
// Requester-side command and data bus of sram_burst_ctrl.
// master: on-chip requester, slave: the controller.
interface sram_burst_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 4
);
    localparam int BE_W = DATA_W / 8;

    logic              CMD_VALID;
    logic              CMD_READY;
    logic              CMD_WRITE;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [BE_W-1:0]   CMD_BE;
    logic [LEN_W-1:0]  CMD_LEN;
    logic [DATA_W-1:0] WR_DATA;
    logic              WR_DATA_ACK;
    logic [DATA_W-1:0] RD_DATA;
    logic              RD_VALID;
    logic              BUSY;

    modport master (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_BE, CMD_LEN, WR_DATA,
        input  CMD_READY, WR_DATA_ACK, RD_DATA, RD_VALID, BUSY
    );

    modport slave (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_BE, CMD_LEN, WR_DATA,
        output CMD_READY, WR_DATA_ACK, RD_DATA, RD_VALID, BUSY
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Asynchronous-SRAM burst controller: single/burst reads and writes with
// byte-lane enables, programmable wait states and address auto-increment.
// All SRAM strobes are active-low and driven from flops.
module sram_burst_ctrl #(
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 4,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic                  CLK_48MHZ,
    input  logic                  RESET,
    sram_burst_ctrl_if.slave      req,
    output logic [ADDR_W-1:0]     SRAM_A,
    inout  wire  [DATA_W-1:0]     SRAM_D,
    output logic [DATA_W/8-1:0]   SRAM_BE_N,
    output logic                  SRAM_CE_N,
    output logic                  SRAM_WE_N,
    output logic                  SRAM_OE_N
);
    localparam int BE_W     = DATA_W / 8;
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        W_ACT,
        W_HOLD,
        R_ACT,
        R_TURN
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [LEN_W-1:0]    beats_q, beats_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                ack_q, ack_d;
    logic                ce_n_q, ce_n_d;
    logic                we_n_q, we_n_d;
    logic                oe_n_q, oe_n_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                drive_q, drive_d;

    // Next-state, datapath and strobe decode; strobes follow the next state
    // so they are registered yet line up with the state they belong to.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        wait_d     = wait_q;
        beats_d    = beats_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        ack_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req.CMD_VALID) begin
                    be_d    = req.CMD_BE;
                    addr_d  = req.CMD_ADDR;
                    beats_d = req.CMD_LEN;
                    wait_d  = '0;
                    if (req.CMD_WRITE) begin
                        wdata_d = req.WR_DATA;
                        ack_d   = 1'b1;
                        state_d = W_ACT;
                    end else begin
                        state_d = R_ACT;
                    end
                end
            end
            W_ACT: begin
                if (wait_q == WAIT_W'(WR_WAIT)) begin
                    wait_d  = '0;
                    state_d = W_HOLD;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            W_HOLD: begin
                if (beats_q != '0) begin
                    beats_d = beats_q - 1'b1;
                    addr_d  = addr_q + 1'b1;
                    wdata_d = req.WR_DATA;
                    ack_d   = 1'b1;
                    state_d = W_ACT;
                end else begin
                    state_d = IDLE;
                end
            end
            R_ACT: begin
                if (wait_q == WAIT_W'(RD_WAIT)) begin
                    rd_data_d  = SRAM_D;
                    rd_valid_d = 1'b1;
                    wait_d     = '0;
                    if (beats_q != '0) begin
                        beats_d = beats_q - 1'b1;
                        addr_d  = addr_q + 1'b1;
                    end else begin
                        state_d = R_TURN;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            R_TURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ce_n_d  = !(state_d == W_ACT || state_d == W_HOLD || state_d == R_ACT);
        we_n_d  = (state_d != W_ACT);
        oe_n_d  = (state_d != R_ACT);
        be_n_d  = ce_n_d ? {BE_W{1'b1}} : ~be_d;
        drive_d = (state_d == W_ACT || state_d == W_HOLD);
    end

    // State and output registers; reset aborts any burst immediately.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            beats_q    <= '0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ack_q      <= 1'b0;
            ce_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            be_n_q     <= '1;
            drive_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of every other flop.
            state_q    <= state_d;
            wait_q     <= wait_d;
            beats_q    <= beats_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ack_q      <= ack_d;
            ce_n_q     <= ce_n_d;
            we_n_q     <= we_n_d;
            oe_n_q     <= oe_n_d;
            be_n_q     <= be_n_d;
            drive_q    <= drive_d;
        end
    end

    assign req.CMD_READY   = (state_q == IDLE);
    assign req.BUSY        = (state_q != IDLE);
    assign req.WR_DATA_ACK = ack_q;
    assign req.RD_DATA     = rd_data_q;
    assign req.RD_VALID    = rd_valid_q;

    assign SRAM_A    = addr_q;
    assign SRAM_BE_N = be_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_D    = drive_q ? wdata_q : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: instance A at default wait states (ADDR_W=18),
// instance B with RD_WAIT=3, WR_WAIT=0 (ADDR_W=8). Each has a simple
// asynchronous-SRAM model on its pins.
module tb_sram_burst_ctrl;
    logic CLK_48MHZ = 1'b0;
    logic RESET     = 1'b0;
    always #10 CLK_48MHZ = ~CLK_48MHZ;

    int checks   = 0;
    int failures = 0;

    // Shared requester stimulus; sel picks which instance sees CMD_VALID.
    bit          sel = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [17:0] cmd_addr = '0;
    logic [1:0]  cmd_be = '0;
    logic [3:0]  cmd_len = '0;
    logic [15:0] wr_data = '0;
    bit          probe_en = 1'b0;
    logic [15:0] probe_pat = '0;

    sram_burst_ctrl_if #(.ADDR_W(18), .DATA_W(16), .LEN_W(4)) ifa ();
    sram_burst_ctrl_if #(.ADDR_W(8),  .DATA_W(16), .LEN_W(4)) ifb ();

    assign ifa.CMD_VALID = cmd_valid & ~sel;
    assign ifa.CMD_WRITE = cmd_write;
    assign ifa.CMD_ADDR  = cmd_addr;
    assign ifa.CMD_BE    = cmd_be;
    assign ifa.CMD_LEN   = cmd_len;
    assign ifa.WR_DATA   = wr_data;
    assign ifb.CMD_VALID = cmd_valid & sel;
    assign ifb.CMD_WRITE = cmd_write;
    assign ifb.CMD_ADDR  = cmd_addr[7:0];
    assign ifb.CMD_BE    = cmd_be;
    assign ifb.CMD_LEN   = cmd_len;
    assign ifb.WR_DATA   = wr_data;

    logic [17:0] a_A;  wire [15:0] a_D;  logic [1:0] a_BE_N;  logic a_CE_N, a_WE_N, a_OE_N;
    logic [7:0]  b_A;  wire [15:0] b_D;  logic [1:0] b_BE_N;  logic b_CE_N, b_WE_N, b_OE_N;

    sram_burst_ctrl #(.ADDR_W(18), .DATA_W(16), .LEN_W(4), .RD_WAIT(1), .WR_WAIT(1)) dut_a (
        .CLK_48MHZ(CLK_48MHZ), .RESET(RESET), .req(ifa.slave),
        .SRAM_A(a_A), .SRAM_D(a_D), .SRAM_BE_N(a_BE_N),
        .SRAM_CE_N(a_CE_N), .SRAM_WE_N(a_WE_N), .SRAM_OE_N(a_OE_N));

    sram_burst_ctrl #(.ADDR_W(8), .DATA_W(16), .LEN_W(4), .RD_WAIT(3), .WR_WAIT(0)) dut_b (
        .CLK_48MHZ(CLK_48MHZ), .RESET(RESET), .req(ifb.slave),
        .SRAM_A(b_A), .SRAM_D(b_D), .SRAM_BE_N(b_BE_N),
        .SRAM_CE_N(b_CE_N), .SRAM_WE_N(b_WE_N), .SRAM_OE_N(b_OE_N));

    // SRAM models: drive the stored word while selected for read, store
    // enabled lanes on every clock edge while selected for write.
    bit [15:0] mem_a [0:(1<<18)-1];
    bit [15:0] mem_b [0:255];

    assign a_D = (!a_CE_N && !a_OE_N && a_WE_N) ? mem_a[a_A] : 16'bz;
    assign a_D = probe_en ? probe_pat : 16'bz;
    assign b_D = (!b_CE_N && !b_OE_N && b_WE_N) ? mem_b[b_A] : 16'bz;

    always @(posedge CLK_48MHZ) begin
        if (!a_CE_N && !a_WE_N)
            for (int l = 0; l < 2; l++)
                if (!a_BE_N[l]) mem_a[a_A][l*8 +: 8] <= a_D[l*8 +: 8];
        if (!b_CE_N && !b_WE_N)
            for (int l = 0; l < 2; l++)
                if (!b_BE_N[l]) mem_b[b_A][l*8 +: 8] <= b_D[l*8 +: 8];
    end

    // Observation mux for the selected instance.
    wire        o_ready = sel ? ifb.CMD_READY   : ifa.CMD_READY;
    wire        o_busy  = sel ? ifb.BUSY        : ifa.BUSY;
    wire        o_ack   = sel ? ifb.WR_DATA_ACK : ifa.WR_DATA_ACK;
    wire        o_valid = sel ? ifb.RD_VALID    : ifa.RD_VALID;
    wire [15:0] o_rd    = sel ? ifb.RD_DATA     : ifa.RD_DATA;
    wire [17:0] o_a     = sel ? {10'd0, b_A}    : a_A;
    wire [1:0]  o_be_n  = sel ? b_BE_N          : a_BE_N;
    wire        o_ce_n  = sel ? b_CE_N          : a_CE_N;
    wire        o_we_n  = sel ? b_WE_N          : a_WE_N;
    wire        o_oe_n  = sel ? b_OE_N          : a_OE_N;
    wire [15:0] o_d     = sel ? b_D             : a_D;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction trace filled by run_cmd; cycle 0 is the accept cycle.
    logic [15:0] beat_data [0:16];
    bit          hold_valid = 1'b0;
    int          ready_cyc;
    int          ack_cyc[$], val_cyc[$];
    logic [17:0] ack_addr[$];
    logic [15:0] val_data[$];
    logic [31:0] strobe_mask;
    logic [1:0]  be_n_c1;

    task automatic run_cmd(input bit s, input bit wr, input logic [17:0] addr,
                           input logic [1:0] be, input logic [3:0] len);
        int beat = 0;
        sel = s;
        ack_cyc.delete(); val_cyc.delete(); ack_addr.delete(); val_data.delete();
        strobe_mask = '0; ready_cyc = -1; be_n_c1 = '0;
        @(negedge CLK_48MHZ);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_be = be; cmd_len = len;
        wr_data = beat_data[0];
        for (int k = 1; k <= 200; k++) begin
            @(negedge CLK_48MHZ);
            if (k == 1) begin cmd_valid = hold_valid; be_n_c1 = o_be_n; end
            if (k == 2) cmd_valid = 1'b0;
            if (o_ack) begin
                ack_cyc.push_back(k); ack_addr.push_back(o_a);
                if (beat < 16) beat++;
                wr_data = beat_data[beat];
            end
            if (o_valid) begin val_cyc.push_back(k); val_data.push_back(o_rd); end
            if ((wr ? !o_we_n : !o_oe_n) && k < 32) strobe_mask[k] = 1'b1;
            if (o_ready && k > 1) begin ready_cyc = k; break; end
        end
        cmd_valid = 1'b0;
        if (ready_cyc < 0) begin
            failures++;
            $display("FAIL timeout: CMD_READY never returned, got busy, expected ready");
        end
    endtask

    typedef struct {
        string       name;
        bit          s;
        bit          wr;
        logic [17:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        bit          hold;
        int          exp_ready;
        int          exp_pulse;
        logic [31:0] exp_mask;
        logic [1:0]  exp_be_n;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] ref_mem [logic [17:0]];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] a, start;
        logic [15:0] w;
        logic [3:0]  len;
        logic [1:0]  be;
        bit          wr;

        //           name          s  wr addr      be     wdata    hold rdy pls mask   be_n   data
        vecs.push_back('{"a_wr_a55a",  0, 1, 18'h00123, 2'b11, 16'hA55A, 0, 4, 1, 32'h6,  2'b00, 16'hA55A});
        vecs.push_back('{"a_rd_a55a",  0, 0, 18'h00123, 2'b11, 16'h0000, 0, 4, 3, 32'h6,  2'b00, 16'hA55A});
        vecs.push_back('{"a_wr_1234",  0, 1, 18'h00200, 2'b11, 16'h1234, 0, 4, 1, 32'h6,  2'b00, 16'h1234});
        vecs.push_back('{"a_wr_be01",  0, 1, 18'h00200, 2'b01, 16'hBEEF, 0, 4, 1, 32'h6,  2'b10, 16'h12EF});
        vecs.push_back('{"a_rd_12ef",  0, 0, 18'h00200, 2'b11, 16'h0000, 0, 4, 3, 32'h6,  2'b00, 16'h12EF});
        vecs.push_back('{"a_wr_be00",  0, 1, 18'h00300, 2'b00, 16'hFFFF, 0, 4, 1, 32'h6,  2'b11, 16'h0000});
        vecs.push_back('{"a_rd_be00",  0, 0, 18'h00300, 2'b00, 16'h0000, 0, 4, 3, 32'h6,  2'b11, 16'h0000});
        vecs.push_back('{"b_rd_empty", 1, 0, 18'h00010, 2'b11, 16'h0000, 0, 6, 5, 32'h1E, 2'b00, 16'h0000});
        vecs.push_back('{"b_wr_hold",  1, 1, 18'h00010, 2'b11, 16'hC3C3, 1, 3, 1, 32'h2,  2'b00, 16'hC3C3});
        vecs.push_back('{"b_rd_c3c3",  1, 0, 18'h00010, 2'b11, 16'h0000, 0, 6, 5, 32'h1E, 2'b00, 16'hC3C3});
        vecs.push_back('{"b_wr_be10",  1, 1, 18'h00011, 2'b10, 16'h0F0F, 1, 3, 1, 32'h2,  2'b01, 16'h0F00});

        for (int i = 0; i <= 16; i++) beat_data[i] = '0;

        // Reset state
        repeat (3) @(negedge CLK_48MHZ);
        check("rst_ready", o_ready, 1);
        check("rst_busy",  o_busy, 0);
        check("rst_ack",   o_ack, 0);
        check("rst_valid", o_valid, 0);
        check("rst_rddata", o_rd, 0);
        check("rst_addr",  o_a, 0);
        check("rst_strobes", {o_be_n, o_ce_n, o_we_n, o_oe_n}, 5'b11111);
        RESET = 1'b1;
        @(negedge CLK_48MHZ);

        // Table-driven single-beat transactions
        foreach (vecs[i]) begin
            beat_data[0] = vecs[i].wdata;
            hold_valid   = vecs[i].hold;
            run_cmd(vecs[i].s, vecs[i].wr, vecs[i].addr, vecs[i].be, 4'd0);
            hold_valid   = 1'b0;
            check({vecs[i].name, "_ready"}, ready_cyc, vecs[i].exp_ready);
            check({vecs[i].name, "_strobes"}, strobe_mask, vecs[i].exp_mask);
            check({vecs[i].name, "_be_n"}, be_n_c1, vecs[i].exp_be_n);
            if (vecs[i].wr) begin
                check({vecs[i].name, "_acks"}, ack_cyc.size(), 1);
                check({vecs[i].name, "_no_valid"}, val_cyc.size(), 0);
                check({vecs[i].name, "_ack_cyc"}, (ack_cyc.size() > 0) ? ack_cyc[0] : -1, vecs[i].exp_pulse);
                check({vecs[i].name, "_mem"}, vecs[i].s ? mem_b[vecs[i].addr[7:0]] : mem_a[vecs[i].addr],
                      vecs[i].exp_data);
            end else begin
                check({vecs[i].name, "_valids"}, val_cyc.size(), 1);
                check({vecs[i].name, "_no_ack"}, ack_cyc.size(), 0);
                check({vecs[i].name, "_valid_cyc"}, (val_cyc.size() > 0) ? val_cyc[0] : -1, vecs[i].exp_pulse);
                check({vecs[i].name, "_rddata"}, (val_data.size() > 0) ? val_data[0] : 16'hDEAD,
                      vecs[i].exp_data);
            end
        end

        // Burst write across the top of the address space
        for (int i = 0; i < 4; i++) beat_data[i] = 16'(i + 1);
        run_cmd(0, 1, 18'h3FFFE, 2'b11, 4'd3);
        check("bw_ready", ready_cyc, 13);
        check("bw_acks", ack_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            a = 18'h3FFFE + 18'(i);
            check($sformatf("bw_ack_cyc%0d", i), (i < ack_cyc.size()) ? ack_cyc[i] : -1, 1 + 3 * i);
            check($sformatf("bw_addr%0d", i), (i < ack_addr.size()) ? ack_addr[i] : 18'h0DEAD, a);
            check($sformatf("bw_mem%0d", i), mem_a[a], 16'(i + 1));
        end

        // Burst read of the same range
        run_cmd(0, 0, 18'h3FFFE, 2'b11, 4'd3);
        check("br_ready", ready_cyc, 10);
        check("br_valids", val_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("br_cyc%0d", i), (i < val_cyc.size()) ? val_cyc[i] : -1, 3 + 2 * i);
            check($sformatf("br_data%0d", i), (i < val_data.size()) ? val_data[i] : 16'hDEAD, 16'(i + 1));
        end

        // Reset during beat 2 of a 4-beat read
        sel = 1'b0;
        @(negedge CLK_48MHZ);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 18'h3FFFE; cmd_be = 2'b11; cmd_len = 4'd3;
        @(negedge CLK_48MHZ); cmd_valid = 1'b0;
        @(negedge CLK_48MHZ);
        @(negedge CLK_48MHZ);
        check("mid_busy_before", o_busy, 1);
        RESET = 1'b0;
        #1;
        check("mid_strobes", {o_be_n, o_ce_n, o_we_n, o_oe_n}, 5'b11111);
        check("mid_valid", o_valid, 0);
        check("mid_rddata", o_rd, 0);
        check("mid_ready", o_ready, 1);
        probe_en = 1'b1; probe_pat = 16'h5A5A; #1;
        check("mid_bus_free_5a", o_d, 16'h5A5A);
        probe_pat = 16'hA5A5; #1;
        check("mid_bus_free_a5", o_d, 16'hA5A5);
        probe_en = 1'b0;
        @(negedge CLK_48MHZ);
        RESET = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_48MHZ);
            check($sformatf("post_rst_quiet%0d", k), {o_valid, o_ack, o_ce_n}, 3'b001);
        end
        run_cmd(0, 0, 18'h00123, 2'b11, 4'd0);
        check("post_rst_ready", ready_cyc, 4);
        check("post_rst_valid_cyc", (val_cyc.size() > 0) ? val_cyc[0] : -1, 3);
        check("post_rst_data", (val_data.size() > 0) ? val_data[0] : 16'hDEAD, 16'hA55A);

        // Randomised traffic against a reference memory, region straddling the wrap
        for (int r = 0; r < 2; r++) begin
            start = r ? 18'h00000 : 18'h3FFF0;
            for (int i = 0; i < 16; i++) begin
                beat_data[i] = 16'($urandom);
                a = start + 18'(i);
                ref_mem[a] = beat_data[i];
            end
            run_cmd(0, 1, start, 2'b11, 4'd15);
            check("seed_acks", ack_cyc.size(), 16);
            check("seed_ready", ready_cyc, 16 * 3 + 1);
        end
        for (int n = 0; n < 40; n++) begin
            start = 18'h3FFF0 + 18'($urandom_range(0, 27));
            len   = 4'($urandom_range(0, 3));
            be    = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++) beat_data[i] = 16'($urandom);
            run_cmd(0, wr, start, be, len);
            if (wr) begin
                check($sformatf("rnd%0d_acks", n), ack_cyc.size(), 32'(len) + 1);
                check($sformatf("rnd%0d_wready", n), ready_cyc, (32'(len) + 1) * 3 + 1);
                for (int i = 0; i <= int'(len); i++) begin
                    a = start + 18'(i);
                    check($sformatf("rnd%0d_waddr%0d", n, i), (i < ack_addr.size()) ? ack_addr[i] : 18'h0DEAD, a);
                    w = ref_mem[a];
                    for (int l = 0; l < 2; l++) if (be[l]) w[l*8 +: 8] = beat_data[i][l*8 +: 8];
                    ref_mem[a] = w;
                end
            end else begin
                check($sformatf("rnd%0d_valids", n), val_cyc.size(), 32'(len) + 1);
                check($sformatf("rnd%0d_rready", n), ready_cyc, (32'(len) + 1) * 2 + 2);
                for (int i = 0; i <= int'(len); i++) begin
                    a = start + 18'(i);
                    check($sformatf("rnd%0d_rdata%0d", n, i), (i < val_data.size()) ? val_data[i] : 16'hDEAD,
                          ref_mem[a]);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_burst_ctrl.md
# sram_burst_ctrl

Parametrised, handshake-driven asynchronous-SRAM controller: single or burst reads and writes, per-byte lane enables, programmable read/write wait states and automatic address increment. It sits between on-chip requesters (telemetry logger, downlink packetiser) and the external SRAM pins. Every SRAM control strobe is active-low. A requester issues a command with a ready/valid handshake and receives one acknowledge or data-valid pulse per beat.

## Interface
- ADDR_W, 18, SRAM word-address width
- DATA_W, 16, data bus width; must be a multiple of 8; byte lanes BE_W = DATA_W/8
- LEN_W, 4, burst-length field width; beats = CMD_LEN+1
- RD_WAIT, 1, extra read-access cycles (≥0)
- WR_WAIT, 1, extra write-pulse cycles (≥0)

Ports:
- CLK_48MHZ  in  1  system clock
- RESET  in  1  asynchronous, active-low reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  high in IDLE; a command is accepted on an edge where CMD_VALID&CMD_READY
- CMD_WRITE  in  1  1=write, 0=read
- CMD_ADDR  in  ADDR_W  start word address
- CMD_BE  in  BE_W  byte-lane enables (1=lane active), constant for the whole burst
- CMD_LEN  in  LEN_W  beats minus one
- WR_DATA  in  DATA_W  write data for the current beat
- WR_DATA_ACK  out  1  one-cycle pulse: WR_DATA for a beat has been taken
- RD_DATA  out  DATA_W  last captured read word
- RD_VALID  out  1  one-cycle pulse per read beat
- BUSY  out  1  high whenever state ≠ IDLE
- SRAM_A  out  ADDR_W  address pins
- SRAM_D  inout  DATA_W  data pins; driven only in W_ACT/W_HOLD, high-Z otherwise
- SRAM_BE_N, SRAM_CE_N, SRAM_WE_N, SRAM_OE_N  out  BE_W/1/1/1  active-low strobes

## Operation
- States: IDLE, W_ACT, W_HOLD, R_ACT, R_TURN.
- On accept, latch addr, BE, beat count and op. Sample WR_DATA on the same edge for writes.
- Next state after accept is W_ACT (write) or R_ACT (read).
- W_ACT lasts WR_WAIT+1 cycles with CE_N=0, WE_N=0, OE_N=1, BE_N=~be and SRAM_D driven with the latched data.
  - WR_DATA_ACK is high in the first W_ACT cycle of each beat.
  - The requester then presents the next beat's data and holds it until the next ack.
- W_HOLD lasts 1 cycle: WE_N=1, with CE_N, BE_N and data unchanged.
  - If beats remain: address+1, WR_DATA sampled, go to W_ACT.
  - Otherwise go to IDLE.
- R_ACT lasts RD_WAIT+1 cycles per beat with CE_N=0, OE_N=0, WE_N=1, BE_N=~be and SRAM_D high-Z.
  - SRAM_D is sampled into RD_DATA at the closing edge of the beat's last cycle. Disabled lanes are captured as-is; the requester ignores them.
  - RD_VALID pulses in the following cycle.
  - If beats remain: address+1 and stay in R_ACT, with OE_N held low across beats.
  - Otherwise go to R_TURN.
- R_TURN lasts 1 cycle with all strobes high, then IDLE. This guarantees one idle bus cycle before any following write drives SRAM_D.
- IDLE: CE_N=WE_N=OE_N=1, BE_N all 1, SRAM_D high-Z, SRAM_A holds the last value.
- Address increment is modulo 2^ADDR_W: max address wraps to 0 mid-burst.
- CMD_BE=0 still runs the full cycle sequence, with BE_N all 1 (memory untouched). RD_VALID and WR_DATA_ACK are still produced per beat.
- CMD_VALID while BUSY is ignored; commands are never queued.

## Timing
- Reset values (immediate, asynchronous):
  - state IDLE, CMD_READY=1, BUSY=0
  - WR_DATA_ACK=0, RD_VALID=0, RD_DATA=0
  - SRAM_A=0, BE_N all 1, CE_N=WE_N=OE_N=1, SRAM_D high-Z
- Reset mid-burst aborts instantly; no further beats or pulses.
- Cycle 0 is the accept cycle.
- Single write: W_ACT in cycles 1..WR_WAIT+1, W_HOLD next, CMD_READY high at cycle WR_WAIT+3 (4 at defaults).
- N-beat write occupies N·(WR_WAIT+2) cycles after accept.
- Single read: R_ACT in cycles 1..RD_WAIT+1; RD_VALID and R_TURN in cycle RD_WAIT+2; CMD_READY at RD_WAIT+3 (4 at defaults).
- N-beat read: RD_VALID pulses spaced RD_WAIT+1 cycles apart. The last pulse coincides with R_TURN.
- All outputs are registered except CMD_READY and BUSY, which are decoded from the state.

## Test plan
- Write 0xA55A to 0x00123, BE=11, LEN=0, defaults, against an SRAM model:
  - WE_N low in cycles 1-2, high in cycle 3.
  - One WR_DATA_ACK in cycle 1.
  - Model holds 0xA55A; CMD_READY returns at cycle 4.
- Read back 0x00123:
  - OE_N low in cycles 1-2.
  - RD_VALID in cycle 3 with RD_DATA=0xA55A.
  - SRAM_D never driven by the block.
- Burst write LEN=3 at 0x3FFFE (ADDR_W=18) with data 1,2,3,4:
  - Addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001; four acks.
  - Burst read of the same range returns 1,2,3,4 on four RD_VALID pulses.
- BE=01 write of 0xBEEF over a location holding 0x1234:
  - Only BE_N[0] asserted; model reads 0x12EF.
- RD_WAIT=3, WR_WAIT=0 build:
  - Single read RD_VALID at cycle 5.
  - Single write CMD_READY at cycle 3.
  - CMD_VALID pulsed while BUSY: no extra access.
- RESET low during beat 2 of a LEN=3 read:
  - All strobes high and SRAM_D high-Z immediately.
  - RD_VALID=0, RD_DATA=0.
  - After release, CMD_READY=1 and a new single read completes normally.
